// File: rtl/button_debouncer.sv
// Multi-channel push-button synchroniser, debouncer and auto-repeat.
// Emits a clean level plus one-cycle press, release, repeat and step pulses.
module button_debouncer #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_step
);

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DL_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PD_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    ARMING,
    PRESSED,
    DISARMING
  } state_t;

  logic [N_BTN-1:0] meta;
  logic [N_BTN-1:0] sync;

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  for (genvar c = 0; c < N_BTN; c++) begin : g_ch
    state_t      state;
    state_t      state_nx;
    logic [31:0] scnt;
    logic [31:0] scnt_nx;
    logic [31:0] hcnt;
    logic [31:0] hcnt_nx;
    logic        rep_ph;
    logic        rep_ph_nx;
    logic        level_q;
    logic        press_q;
    logic        release_q;
    logic        repeat_q;
    logic        level_nx;
    logic        press_nx;
    logic        release_nx;
    logic        repeat_nx;
    logic [31:0] h_last;
    logic        fire;

    // rep_ph selects the first-delay or the steady-period limit
    assign h_last = rep_ph ? PD_LAST : DL_LAST;
    assign fire   = REPEAT_EN && (hcnt == h_last);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= RELEASED;
        scnt      <= '0;
        hcnt      <= '0;
        rep_ph    <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state     <= state_nx;
        scnt      <= scnt_nx;
        hcnt      <= hcnt_nx;
        rep_ph    <= rep_ph_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        repeat_q  <= repeat_nx;
      end
    end

    // Next state and counter updates
    always_comb begin
      state_nx  = state;
      scnt_nx   = scnt;
      hcnt_nx   = hcnt;
      rep_ph_nx = rep_ph;
      unique case (state)
        RELEASED: begin
          if (sync[c]) begin
            state_nx = ARMING;
            scnt_nx  = '0;
          end
        end
        ARMING: begin
          if (!sync[c]) begin
            state_nx = RELEASED;
          end else if (scnt == DB_LAST) begin
            state_nx  = PRESSED;
            hcnt_nx   = '0;
            rep_ph_nx = 1'b0;
          end else begin
            scnt_nx = scnt + 32'd1;
          end
        end
        PRESSED: begin
          if (!sync[c]) begin
            state_nx = DISARMING;
            scnt_nx  = '0;
          end else if (fire) begin
            hcnt_nx   = '0;
            rep_ph_nx = 1'b1;
          end else if (REPEAT_EN) begin
            hcnt_nx = hcnt + 32'd1;
          end
        end
        DISARMING: begin
          if (sync[c]) begin
            state_nx = PRESSED;
          end else if (scnt == DB_LAST) begin
            state_nx = RELEASED;
          end else begin
            scnt_nx = scnt + 32'd1;
          end
        end
      endcase
    end

    // Next values of the level and the one-cycle event pulses
    always_comb begin
      level_nx   = level_q;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      repeat_nx  = 1'b0;
      unique case (state)
        ARMING: begin
          if (sync[c] && scnt == DB_LAST) begin
            level_nx = 1'b1;
            press_nx = 1'b1;
          end
        end
        PRESSED: begin
          if (sync[c] && fire) repeat_nx = 1'b1;
        end
        DISARMING: begin
          if (!sync[c] && scnt == DB_LAST) begin
            level_nx   = 1'b0;
            release_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end

    assign btn_level[c]   = level_q;
    assign btn_press[c]   = press_q;
    assign btn_release[c] = release_q;
    assign btn_repeat[c]  = repeat_q;
  end

  assign btn_step = btn_press | btn_repeat;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing,
// checked against a run-length / hold-time reference model.
module tb_button_debouncer;

  localparam int N   = 2;
  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic [N-1:0] btn_step;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_p1, m_p2, m_prev;
  logic [N-1:0] m_level, m_press, m_release, m_repeat;
  int           m_run  [N];
  int           m_hold [N];

  logic [5*N-1:0] act;
  assign act = {btn_level, btn_press, btn_release, btn_repeat, btn_step};

  button_debouncer #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .btn_step   (btn_step)
  );

  always #5 clk = ~clk;

  function automatic logic [5*N-1:0] exp_vec();
    return {m_level, m_press, m_release, m_repeat, m_press | m_repeat};
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_prev = '0;
    m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
    end
  endtask

  // A change is accepted once DB+1 equal synchronised samples are seen.
  // Repeats fire after DLY, DLY+PER, ... cycles of uninterrupted hold.
  task automatic model_step();
    logic [N-1:0] smp;
    smp = m_p2;
    for (int c = 0; c < N; c++) begin
      m_press[c] = 1'b0;
      m_release[c] = 1'b0;
      m_repeat[c] = 1'b0;
      if (smp[c] == m_prev[c]) begin
        if (m_run[c] < 1000000) m_run[c]++;
      end else begin
        m_run[c] = 1;
      end
      if (m_level[c] && smp[c] && m_prev[c]) begin
        m_hold[c]++;
        if (m_hold[c] >= DLY && (m_hold[c] - DLY) % PER == 0)
          m_repeat[c] = 1'b1;
      end
      if (smp[c] != m_level[c] && m_run[c] == DB + 1) begin
        if (smp[c]) begin
          m_press[c] = 1'b1;
          m_hold[c]  = 0;
        end else begin
          m_release[c] = 1'b1;
        end
        m_level[c] = smp[c];
      end
      m_prev[c] = smp[c];
    end
    m_p2 = m_p1;
    m_p1 = btn_raw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    btn_raw = '0;
    for (int i = 0; i < 14; i++) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", act);
    end
    btn_raw = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=0", act);
    end
    btn_raw = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (act !== '0 || act !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 2'b01;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL clean_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
      checks++;
      if (btn_press !== ((i == 6) ? 2'b01 : 2'b00) ||
          btn_level !== ((i >= 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_press cyc%0d got prs=%b lvl=%b", i, btn_press, btn_level);
      end
    end
    drive_idle();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 16; i++) begin
      btn_raw = (i < 5) ? {1'b0, (i % 2 == 0)} : 2'b01;
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL bounce_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
      checks++;
      if (btn_press !== ((i == 10) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL bounce_press cyc%0d got=%b exp=%b", i, btn_press, (i == 10));
      end
    end
    drive_idle();
  endtask

  task automatic test_hold_repeat();
    logic er;
    for (int i = 0; i < 48; i++) begin
      btn_raw = (i < 36) ? 2'b01 : 2'b00;
      tick();
      er = (i >= 16) && (i <= 37) && ((i - 16) % 3 == 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL hold_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
      checks++;
      if (btn_repeat[0] !== er || btn_step[0] !== (er || i == 6) ||
          btn_release[0] !== (i == 42)) begin
        errors++;
        $display("FAIL hold_cadence cyc%0d got rep=%b stp=%b rel=%b exp rep=%b",
                 i, btn_repeat[0], btn_step[0], btn_release[0], er);
      end
    end
    drive_idle();
  endtask

  task automatic test_release_bounce();
    logic er;
    for (int i = 0; i < 48; i++) begin
      btn_raw = (i < 35 && i != 20 && i != 21) ? 2'b01 : 2'b00;
      tick();
      er = (i == 16 || i == 19 || i == 25 || i == 28 || i == 31 || i == 34);
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL relb_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
      checks++;
      if (btn_repeat[0] !== er || btn_release[0] !== (i == 41) ||
          btn_level[0] !== (i >= 6 && i < 41)) begin
        errors++;
        $display("FAIL relb_directed cyc%0d got rep=%b rel=%b lvl=%b exp rep=%b",
                 i, btn_repeat[0], btn_release[0], btn_level[0], er);
      end
    end
    drive_idle();
  endtask

  task automatic test_simultaneous();
    btn_raw = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL simul_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
      checks++;
      if (btn_press !== ((i == 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_press cyc%0d got=%b", i, btn_press);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_hold();
    btn_raw = 2'b01;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (btn_press !== 2'b01) begin
      errors++;
      $display("FAIL midrst_pre got prs=%b exp=01", btn_press);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL midrst_async got=%h exp=0", act);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL midrst_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
      checks++;
      if (btn_press !== ((i == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL midrst_press cyc%0d got=%b", i, btn_press);
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    int left [N];
    for (int c = 0; c < N; c++) left[c] = 0;
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < N; c++) begin
        if (left[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                : $urandom_range(1, 7);
        end
        left[c]--;
      end
      tick();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cyc%0d got=%h exp=%h", i, act, exp_vec());
      end
    end
    drive_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
